fp_batch_ctrl: RTL and testbench

- Batch sequencer for the fix(8.8)-to-float(16) conversion engine.
- Walks COUNT 16-bit operands stored little-endian in data memory. For each operand it reads two bytes, hands the word to the engine over a start/done handshake, and writes the 16-bit result back as two bytes.
- Sits between the testbench-facing start/done pair and the engine and data memory. It is the only master of the data memory port while busy.

---
 rtl/fp_ctrl_pkg.sv | 30 +++
 rtl/fp_ctrl_watchdog.sv | 36 +++
 rtl/fp_batch_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_fp_batch_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_ctrl_pkg
// Brief    : Shared types and constants for the fix(8.8)->float16 batch
//            sequencer (state encoding, NaN substitute, byte-lane offsets).
// Revision : 1.0 - initial release
// ============================================================================
package fp_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_LO    = 4'd1,
    S_RD_HI    = 4'd2,
    S_CAPT     = 4'd3,
    S_ENG_GO   = 4'd4,
    S_ENG_WAIT = 4'd5,
    S_WR_LO    = 4'd6,
    S_WR_HI    = 4'd7,
    S_NEXT     = 4'd8
  } state_t;

  // Quiet NaN written in place of a result the engine never delivered.
  localparam logic [15:0] FP16_NAN = 16'h7E00;

  // Byte-lane offsets within a little-endian 16-bit word.
  localparam int LO = 0;
  localparam int HI = 1;

endpackage
`default_nettype wire

// File: rtl/fp_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : fp_ctrl_watchdog
// Brief    : Cycle counter that flags expiry once TIMEOUT enabled cycles have
//            elapsed since the last clear. Used only when WATCHDOG_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module fp_ctrl_watchdog
  import fp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles, saturating at the limit so expire stays asserted.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable && !expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expire = (r_cnt == CW'(TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/fp_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_batch_ctrl
// Brief    : Batch sequencer for the fix(8.8)->float16 engine. Reads COUNT
//            little-endian operands from data memory, runs each through the
//            engine via start/done, writes results back as two bytes.
//            Optional macro WATCHDOG_EN adds an engine timeout that sets err
//            and substitutes a float16 NaN result.
// Revision : 1.0 - initial release
// ============================================================================
module fp_batch_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64,
  parameter int CNT_W    = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              eng_start,
  output logic [15:0]       eng_operand,
  input  logic              eng_done,
  input  logic [15:0]       eng_result
);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_index;
  logic [15:0]         r_operand;
  logic [15:0]         r_result;
  logic                r_eng_done_prev;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_rd;
  logic                w_wr;
  logic                w_eng_go;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_wdata;
  logic                w_eng_rise;
  logic                w_expire;
  logic                w_last;
  logic [ADDR_W-1:0]   w_pair_off;
  logic [ADDR_W-1:0]   w_src_addr;
  logic [ADDR_W-1:0]   w_dst_addr;

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign w_pair_off = ADDR_W'({r_index, 1'b0});
  assign w_src_addr = ADDR_W'(SRC_BASE) + w_pair_off;
  assign w_dst_addr = ADDR_W'(DST_BASE) + w_pair_off;

  // A level still high from the previous operand is not an edge.
  assign w_eng_rise = eng_done && !r_eng_done_prev;

  // count==0 batches pass straight through NEXT without touching memory.
  assign w_last = (r_count == '0) || ((r_index + CNT_W'(1)) == r_count);

`ifdef WATCHDOG_EN
  fp_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_state != S_ENG_WAIT),
    .enable (r_state == S_ENG_WAIT),
    .expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expire         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state memory/engine strobes.
  always_comb begin
    w_next   = r_state;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_eng_go = 1'b0;
    w_addr   = '0;
    w_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (count == '0) ? S_NEXT : S_RD_LO;
        end
      end
      S_RD_LO: begin
        w_rd   = 1'b1;
        w_addr = w_src_addr + ADDR_W'(LO);
        w_next = S_RD_HI;
      end
      S_RD_HI: begin
        w_rd   = 1'b1;
        w_addr = w_src_addr + ADDR_W'(HI);
        w_next = S_CAPT;
      end
      S_CAPT: begin
        w_next = S_ENG_GO;
      end
      S_ENG_GO: begin
        w_eng_go = 1'b1;
        w_next   = S_ENG_WAIT;
      end
      S_ENG_WAIT: begin
        if (w_eng_rise || w_expire) begin
          w_next = S_WR_LO;
        end
      end
      S_WR_LO: begin
        w_wr    = 1'b1;
        w_addr  = w_dst_addr + ADDR_W'(LO);
        w_wdata = r_result[7:0];
        w_next  = S_WR_HI;
      end
      S_WR_HI: begin
        w_wr    = 1'b1;
        w_addr  = w_dst_addr + ADDR_W'(HI);
        w_wdata = r_result[15:8];
        w_next  = S_NEXT;
      end
      S_NEXT: begin
        w_next = w_last ? S_IDLE : S_RD_LO;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: batch bookkeeping, operand assembly and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count         <= '0;
      r_index         <= '0;
      r_operand       <= '0;
      r_result        <= '0;
      r_eng_done_prev <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_eng_done_prev <= eng_done;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count <= count;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_RD_HI: r_operand[7:0]  <= mem_rdata;
        S_CAPT:  r_operand[15:8] <= mem_rdata;
        S_ENG_WAIT: begin
          if (w_eng_rise) begin
            r_result <= eng_result;
          end else if (w_expire) begin
            r_result <= FP16_NAN;
            r_err    <= 1'b1;
          end
        end
        S_NEXT: begin
          r_index <= r_index + CNT_W'(1);
          if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are suppressed in the reset cycle so an interrupted write
  // never lands.
  assign mem_rd      = w_rd && !reset;
  assign mem_wr      = w_wr && !reset;
  assign eng_start   = w_eng_go && !reset;
  assign mem_addr    = w_addr;
  assign mem_wdata   = w_wdata;
  assign eng_operand = r_operand;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_batch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_batch_ctrl
// Brief    : Scoreboard bench for fp_batch_ctrl with behavioural data memory
//            and engine models. Define WATCHDOG_EN to include the timeout case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_batch_ctrl;

  localparam int ENG_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  count;
  logic        busy, done, err;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        eng_start;
  logic [15:0] eng_operand;
  logic        eng_done;
  logic [15:0] eng_result;

  fp_batch_ctrl #(
    .ADDR_W   (8),
    .SRC_BASE (0),
    .DST_BASE (64),
    .CNT_W    (5),
    .TIMEOUT  (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .eng_start   (eng_start),
    .eng_operand (eng_operand),
    .eng_done    (eng_done),
    .eng_result  (eng_result)
  );

  always #5 clk = ~clk;

  // Data memory: one-cycle read latency, plus a bench preload port.
  logic [7:0] mem [256];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Engine: done rises ENG_LAT cycles after the start pulse (pulse cycle
  // included) and stays high until the next start.
  logic        eng_never;
  logic        e_busy;
  int          e_cnt;
  logic [15:0] e_res;

  function automatic logic [15:0] conv(input logic [15:0] op);
    case (op)
      16'h0100: conv = 16'h3C00;
      16'h0080: conv = 16'h3800;
      16'hFF00: conv = 16'hBC00;
      16'h0000: conv = 16'h0000;
      default:  conv = 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      eng_done   <= 1'b0;
      eng_result <= 16'h0;
      e_busy     <= 1'b0;
      e_cnt      <= 0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      e_busy   <= 1'b1;
      e_cnt    <= 0;
      e_res    <= conv(eng_operand);
    end else if (e_busy && !eng_never) begin
      e_cnt <= e_cnt + 1;
      if (e_cnt + 1 == ENG_LAT - 1) begin
        eng_done   <= 1'b1;
        eng_result <= e_res;
        e_busy     <= 1'b0;
      end
    end
  end

  // Scoreboard state.
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr, n_rd, n_eng;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: pops one expected write per observed mem_wr strobe.
  task automatic monitor_loop();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (mem_rd || mem_wr) chk("rd_wr_exclusive", {63'd0, mem_rd && mem_wr}, 64'd0);
      if (mem_rd) n_rd++;
      if (eng_start) n_eng++;
      if (mem_wr) begin
        n_wr++;
        chk("write_was_expected", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_addr_data", {48'd0, mem_addr, mem_wdata}, {48'd0, e});
        end
      end
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic clr_counts();
    n_wr = 0; n_rd = 0; n_eng = 0;
  endtask

  // Returns at the negedge following the accepting edge.
  task automatic start_batch(input logic [4:0] c);
    start = 1'b1;
    count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n = number of edges from start acceptance (that edge is 1) until done.
  task automatic wait_done(input string name, input int bound, output int n);
    n = 1;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic wait_sig(input string name, input int bound, input int which);
    int k;
    k = 0;
    while (k < bound && !((which == 0) ? eng_start : (mem_wr && mem_addr == 8'd66))) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_seen"}, {63'd0, k < bound}, 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; count = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; eng_never = 1'b0;
    n_wr = 0; n_rd = 0; n_eng = 0;
    fork
      monitor_loop();
    join_none
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state",
        {26'd0, busy, done, err, mem_rd, mem_wr, eng_start, mem_addr, mem_wdata, eng_operand},
        64'd0);

    // T1: single operand 1.0 -> 3C00, done on edge 18.
    poke(8'd0, 8'h00); poke(8'd1, 8'h01);
    push_exp(8'd64, 8'h00); push_exp(8'd65, 8'h3C);
    clr_counts();
    start_batch(5'd1);
    chk("t1_busy_set", {63'd0, busy}, 64'd1);
    wait_done("t1", 200, n);
    chk("t1_done_cycle", 64'(n), 64'd18);
    chk("t1_busy_low", {63'd0, busy}, 64'd0);
    chk("t1_mem64", {56'd0, mem[64]}, 64'h00);
    chk("t1_mem65", {56'd0, mem[65]}, 64'h3C);
    chk("t1_eng_starts", 64'(n_eng), 64'd1);

    // T2: three operands.
    poke(8'd0, 8'h80); poke(8'd1, 8'h00);
    poke(8'd2, 8'h00); poke(8'd3, 8'hFF);
    poke(8'd4, 8'h00); poke(8'd5, 8'h00);
    push_exp(8'd64, 8'h00); push_exp(8'd65, 8'h38);
    push_exp(8'd66, 8'h00); push_exp(8'd67, 8'hBC);
    push_exp(8'd68, 8'h00); push_exp(8'd69, 8'h00);
    clr_counts();
    start_batch(5'd3);
    wait_done("t2", 300, n);
    chk("t2_eng_starts", 64'(n_eng), 64'd3);
    chk("t2_reads", 64'(n_rd), 64'd6);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // T3: empty batch; done was set, start must clear it.
    clr_counts();
    start_batch(5'd0);
    chk("t3_done_cleared", {63'd0, done}, 64'd0);
    wait_done("t3", 10, n);
    chk("t3_done_cycle", 64'(n), 64'd2);
    chk("t3_no_access", 64'(n_rd + n_wr + n_eng), 64'd0);

    // T4: start during ENG_WAIT ignored, then rerun from IDLE.
    poke(8'd0, 8'h00); poke(8'd1, 8'h01);
    poke(8'd2, 8'h80); poke(8'd3, 8'h00);
    push_exp(8'd64, 8'h00); push_exp(8'd65, 8'h3C);
    push_exp(8'd66, 8'h00); push_exp(8'd67, 8'h38);
    clr_counts();
    start_batch(5'd2);
    wait_sig("t4_eng_start", 50, 0);
    repeat (2) @(negedge clk);
    start = 1'b1; count = 5'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4a", 300, n);
    repeat (3) @(negedge clk);
    chk("t4a_writes", 64'(n_wr), 64'd4);
    chk("t4a_queue_empty", 64'(exp_q.size()), 64'd0);
    push_exp(8'd64, 8'h00); push_exp(8'd65, 8'h3C);
    push_exp(8'd66, 8'h00); push_exp(8'd67, 8'h38);
    clr_counts();
    start_batch(5'd2);
    chk("t4b_done_cleared", {63'd0, done}, 64'd0);
    wait_done("t4b", 300, n);
    chk("t4b_writes", 64'(n_wr), 64'd4);

    // T5: reset during WR_HI of operand 1.
    poke(8'd64, 8'hA5); poke(8'd65, 8'hA5);
    poke(8'd66, 8'hA5); poke(8'd67, 8'hA5);
    push_exp(8'd64, 8'h00); push_exp(8'd65, 8'h3C); push_exp(8'd66, 8'h00);
    start_batch(5'd2);
    wait_sig("t5_wr_lo_op1", 200, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_outputs_idle",
        {26'd0, busy, done, err, mem_rd, mem_wr, eng_start, mem_addr, mem_wdata, eng_operand},
        64'd0);
    repeat (2) @(negedge clk);
    chk("t5_mem66", {56'd0, mem[66]}, 64'h00);
    chk("t5_mem67", {56'd0, mem[67]}, 64'hA5);
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef WATCHDOG_EN
    // T6: engine never answers; NaN substituted, err set.
    eng_never = 1'b1;
    poke(8'd0, 8'h00); poke(8'd1, 8'h01);
    push_exp(8'd64, 8'h00); push_exp(8'd65, 8'h7E);
    start_batch(5'd1);
    wait_done("t6", 300, n);
    chk("t6_err", {63'd0, err}, 64'd1);
    chk("t6_mem64", {56'd0, mem[64]}, 64'h00);
    chk("t6_mem65", {56'd0, mem[65]}, 64'h7E);
    eng_never = 1'b0;
`else
    // Without the watchdog err stays low through a normal batch.
    push_exp(8'd64, 8'h00); push_exp(8'd65, 8'h3C);
    poke(8'd0, 8'h00); poke(8'd1, 8'h01);
    start_batch(5'd1);
    wait_done("t6", 300, n);
    chk("t6_err_tied", {63'd0, err}, 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
